// File: rtl/ifft8_if.sv
// ifft8_if: stream bundle for ifft8_seq.
//   in_data/in_valid/in_ready    : spectral samples X0..X7 in, {re[31:16], im[15:0]}
//   out_data/out_valid/out_ready : time samples x0..x7 out, {re, im}
//   out_index                    : time index n of out_data
//   out_last                     : high together with n = 7
// master = traffic source/sink (test harness), slave = the transform block.
interface ifft8_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_index;
    logic        out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_index, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_index, out_last
    );
endinterface

// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point inverse FFT, complex Q4.11, one shared
// radix-2 butterfly (decimation in time, bit-reversed load, natural-order out).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ifft8_if.slave stream (samples in, results out)
//   busy  : high while computing or unloading a frame
// Parameters: FRAC = fraction bits (1.0 = 1<<FRAC),
//             SCALE = 1 halves every stage (total 1/8), 0 = wrap mod 2^16.
module ifft8_seq #(
    parameter int FRAC  = 11,
    parameter bit SCALE = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    ifft8_if.slave bus,
    output logic   busy
);

    typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Conjugate twiddles e^{+j*2*pi*t/8}, {re, im}.
    function automatic logic [31:0] twiddle(input logic [1:0] t);
        case (t)
            2'd0:    return {16'h0800, 16'h0000};
            2'd1:    return {16'h05A8, 16'h05A8};
            2'd2:    return {16'h0000, 16'h0800};
            default: return {16'hFA58, 16'h05A8};
        endcase
    endfunction

    // 17-bit butterfly sum down to 16 bits: halve, or keep low bits (wrap).
    function automatic logic [15:0] narrow(input logic [16:0] s);
        return SCALE ? s[16:1] : s[15:0];
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  load_cnt_q, load_cnt_d;
    logic [3:0]  cmp_cnt_q, cmp_cnt_d;
    logic [31:0] bank_q [8];
    logic [31:0] bank_d [8];
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_index_q, out_index_d;
    logic        out_last_q, out_last_d;

    // ---- butterfly addressing: cmp_cnt = {stage, butterfly} ----
    logic [1:0] stage, bf;
    logic [2:0] top_idx, bot_idx;
    logic [1:0] tw_idx;

    assign stage = cmp_cnt_q[3:2];
    assign bf    = cmp_cnt_q[1:0];

    always_comb begin
        // NOTE: every branch assigns every output, so no latch can be inferred.
        top_idx = 3'd0;
        bot_idx = 3'd0;
        tw_idx  = 2'd0;
        case (stage)
            2'd0: begin                     // h = 1: pairs (2b, 2b+1), t = 0
                top_idx = {bf, 1'b0};
                bot_idx = {bf, 1'b1};
                tw_idx  = 2'd0;
            end
            2'd1: begin                     // h = 2: top = 4g + j, t = 2j
                top_idx = {bf[1], 1'b0, bf[0]};
                bot_idx = {bf[1], 1'b1, bf[0]};
                tw_idx  = {bf[0], 1'b0};
            end
            default: begin                  // h = 4: top = j, t = j
                top_idx = {1'b0, bf};
                bot_idx = {1'b1, bf};
                tw_idx  = bf;
            end
        endcase
    end

    // ---- butterfly datapath ----
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im, p_re, p_im;
    logic signed [31:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [32:0] p_re_full, p_im_full, p_re_sh, p_im_sh;
    logic signed [16:0] s_re, s_im, d_re, d_im;
    logic [31:0]        bf_top, bf_bot;
    logic               unused_prod_bits;

    assign {a_re, a_im} = bank_q[top_idx];
    assign {b_re, b_im} = bank_q[bot_idx];
    assign {w_re, w_im} = twiddle(tw_idx);

    assign m_rr = b_re * w_re;
    assign m_ii = b_im * w_im;
    assign m_ri = b_re * w_im;
    assign m_ir = b_im * w_re;

    assign p_re_full = {m_rr[31], m_rr} - {m_ii[31], m_ii};
    assign p_im_full = {m_ri[31], m_ri} + {m_ir[31], m_ir};
    assign p_re_sh   = p_re_full >>> FRAC;
    assign p_im_sh   = p_im_full >>> FRAC;
    assign p_re      = p_re_sh[15:0];
    assign p_im      = p_im_sh[15:0];
    // Upper product bits are discarded by design (Q4.11 wrap).
    assign unused_prod_bits = ^{p_re_sh[32:16], p_im_sh[32:16]};

    assign s_re = {a_re[15], a_re} + {p_re[15], p_re};
    assign s_im = {a_im[15], a_im} + {p_im[15], p_im};
    assign d_re = {a_re[15], a_re} - {p_re[15], p_re};
    assign d_im = {a_im[15], a_im} - {p_im[15], p_im};

    assign bf_top = {narrow(s_re), narrow(s_im)};
    assign bf_bot = {narrow(d_re), narrow(d_im)};

    // ---- control ----
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        cmp_cnt_d   = cmp_cnt_q;
        bank_d      = bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    bank_d[bitrev3(load_cnt_q)] = bus.in_data;
                    load_cnt_d = load_cnt_q + 3'd1;   // wraps to 0 after k = 7
                    if (load_cnt_q == 3'd7) state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                bank_d[top_idx] = bf_top;
                bank_d[bot_idx] = bf_bot;
                if (cmp_cnt_q == 4'd11) begin
                    cmp_cnt_d = 4'd0;
                    state_d   = ST_UNLOAD;
                end else begin
                    cmp_cnt_d = cmp_cnt_q + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (!out_valid_q) begin
                    // First result of the frame: out_index_q is 0 here.
                    out_valid_d = 1'b1;
                    out_data_d  = bank_q[out_index_q];
                    out_last_d  = (out_index_q == 3'd7);
                end else if (bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_index_d = 3'd0;
                        out_last_d  = 1'b0;
                        state_d     = ST_LOAD;
                    end else begin
                        out_index_d = out_index_q + 3'd1;
                        out_data_d  = bank_q[out_index_d];
                        out_last_d  = (out_index_d == 3'd7);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Registered so in_ready stays low while rst_n is asserted.
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            cmp_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            // NOTE: the bank is a small flop array, so it is reset explicitly
            // to guarantee no residue from an aborted frame.
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous.
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cmp_cnt_q   <= cmp_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            bank_q      <= bank_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != ST_LOAD);

endmodule

// File: tb/tb_ifft8_seq.sv
// tb_ifft8_seq: scoreboard bench for ifft8_seq (FRAC = 11, SCALE = 1).
// Expected samples are queued when a frame is sent and popped as results
// are handshaken out.
module tb_ifft8_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    ifft8_if bus ();

    ifft8_seq #(.FRAC(11), .SCALE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        int          tol;   // 0: exact 32-bit compare, else per-component window
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_hs = 0;
    int   rise_cyc = 0;
    int   last_in_cyc = 0;
    bit   bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
        end
    endtask

    // ---- out_ready driver: 1,0,0 repeating under backpressure ----
    initial begin
        int ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                bus.out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // ---- output monitor / scoreboard ----
    logic [31:0] prev_data;
    logic [2:0]  prev_idx;
    logic        prev_last;
    bit          prev_stall = 0;
    bit          prev_valid = 0;
    bit          want_ready = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            prev_valid = 0;
            want_ready = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_index", bus.out_index, prev_idx);
                check("hold_last", bus.out_last, prev_last);
            end
            if (want_ready) begin
                check("in_ready_after_last", bus.in_ready, 1);
                check("valid_drop_after_last", bus.out_valid, 0);
                want_ready = 0;
            end
            if (bus.out_valid && !prev_valid) rise_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                out_hs++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.tol == 0) begin
                        check("data", bus.out_data, mon_e.data);
                    end else begin
                        check("rt_re", int'($signed(bus.out_data[31:16])), int'($signed(mon_e.data[31:16])), mon_e.tol);
                        check("rt_im", int'($signed(bus.out_data[15:0])), int'($signed(mon_e.data[15:0])), mon_e.tol);
                    end
                    check("index", bus.out_index, mon_e.idx);
                    check("last", bus.out_last, (mon_e.idx == 3'd7));
                end
                if (bus.out_last) want_ready = 1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_valid = bus.out_valid;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_index;
            prev_last  = bus.out_last;
        end
    end

    // ---- stimulus helpers (entered and left at #1 after a rising edge) ----
    task automatic send_frame(input logic [31:0] xs [8], input bit gaps);
        int guard;
        for (int k = 0; k < 8; k++) begin
            if (gaps && (k % 3 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                repeat (2) begin @(posedge clk); #1; end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = xs[k];
            guard = 0;
            while (!bus.in_ready && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) check("in_ready_timeout", guard, 0);
            @(posedge clk); #1;
        end
        last_in_cyc  = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic push_expected(input logic [31:0] ys [8], input int tol);
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            e.data = ys[n];
            e.idx  = 3'(n);
            e.tol  = tol;
            sb.push_back(e);
        end
    endtask

    task automatic wait_out(input int target);
        int guard = 0;
        while (out_hs < target && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("frame_done", out_hs, target);
    endtask

    task automatic run_frame(input logic [31:0] xs [8], input logic [31:0] ys [8], input int tol, input bit gaps);
        int target;
        target = out_hs + 8;
        push_expected(ys, tol);
        send_frame(xs, gaps);
        wait_out(target);
        check("latency", rise_cyc - last_in_cyc, 13);
    endtask

    // Forward DFT in real arithmetic, rounded to Q4.11.
    task automatic fwd_dft(input int xr [8], input int xi [8], output logic [31:0] xs [8]);
        real sr, si, ang;
        logic [15:0] re16, im16;
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
                sr += real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
                si += real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
            end
            re16 = 16'(int'(sr));
            im16 = 16'(int'(si));
            xs[k] = {re16, im16};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] fx [8];
        logic [31:0] fy [8];
        int xr [8];
        int xi [8];
        int hs_before;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // ---- impulse ----
        fx = '{32'h0800_0000, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 8; n++) fy[n] = 32'h0100_0000;
        run_frame(fx, fy, 0, 1'b0);

        // ---- DC spectrum ----
        for (int n = 0; n < 8; n++) fx[n] = 32'h0800_0000;
        fy = '{32'h0800_0000, 0, 0, 0, 0, 0, 0, 0};
        run_frame(fx, fy, 0, 1'b0);

        // ---- single bin X1, junk on in_data/in_valid during compute ----
        fx = '{0, 32'h0800_0000, 0, 0, 0, 0, 0, 0};
        fy = '{32'h0100_0000, 32'h00B5_00B5, 32'h0000_0100, 32'hFF4B_00B5,
               32'hFF00_0000, 32'hFF4B_FF4B, 32'h0000_FF00, 32'h00B5_FF4B};
        begin
            int target;
            target = out_hs + 8;
            push_expected(fy, 0);
            send_frame(fx, 1'b0);
            bus.in_valid = 1'b1;
            repeat (5) begin
                bus.in_data = $urandom;
                check("in_ready_low_compute", bus.in_ready, 0);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            wait_out(target);
            check("latency", rise_cyc - last_in_cyc, 13);
        end

        // ---- impulse under backpressure with input gaps ----
        fx = '{32'h0800_0000, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 8; n++) fy[n] = 32'h0100_0000;
        hs_before = out_hs;
        bp_mode = 1'b1;
        run_frame(fx, fy, 0, 1'b1);
        bp_mode = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("bp_handshakes", out_hs - hs_before, 8);

        // ---- reset during compute cycle 5, then clean impulse ----
        for (int n = 0; n < 8; n++) fx[n] = 32'h0800_0000;
        send_frame(fx, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        check("busy_compute", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_abort", bus.in_ready, 1);
        fx = '{32'h0800_0000, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 8; n++) fy[n] = 32'h0100_0000;
        run_frame(fx, fy, 0, 1'b0);

        // ---- random round trips through a forward DFT ----
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                xr[n] = int'($urandom_range(0, 2046)) - 1023;
                xi[n] = int'($urandom_range(0, 2046)) - 1023;
                fy[n] = {16'(xr[n]), 16'(xi[n])};
            end
            fwd_dft(xr, xi, fx);
            run_frame(fx, fy, 4, (f == 1));
        end

        repeat (4) begin @(posedge clk); #1; end
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
